ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 16-bit pipeline.
- Consumes the forwarded operands: A from the operand-A forwarding mux, B from the operand-B forwarding mux.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline via a stall output, then presents the 16-bit result for capture into EX/MEM.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  ID/EX holds a mul/div op this cycle; operands valid.
- op  input  2  00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR; all unsigned.
- op_a  input  WIDTH  forwarded operand A.
- op_b  input  WIDTH  forwarded operand B (forwarding-mux B output).
- flush  input  1  branch/exception squash; aborts an in-flight op.
- stall  output  1  freeze IF/ID/ID-EX and forwarding selects.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  selected product half, quotient or remainder.
- div_zero  output  1  set with done when a DIV op had op_b==0.

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset (rst=1 at edge, any state): state=IDLE, counter=0, internal regs=0, result=0, done=0, div_zero=0; stall=0 in the cycle after reset.
- IDLE or DONE with start=1:
  - Latch op, op_a, op_b, and div_zero_r=(op[1]&(op_b==0)).
  - Clear accumulator; counter=0; go to RUN.
- IDLE or DONE with start=0: go to IDLE.
- RUN: one iteration per cycle; counter++.
  - MUL: if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH product register; shift right 1 (carry kept).
  - DIV: shift {rem,quot} left 1; if rem>=divisor, subtract and set quot LSB.
  - When counter==WIDTH-1, go to DONE.
- DONE (exactly 1 cycle): done=1; result and div_zero registered and valid.
  - result is held in all later cycles until the next DONE.
  - div_zero drops to 0 when the next op starts.
- Latency: start seen at edge N -> RUN for edges N+1..N+WIDTH -> done=1 in the cycle after edge N+WIDTH (WIDTH+1 cycles after the start cycle).
- stall = (start & (IDLE|DONE)) | RUN.
  - stall is combinational from start so the issuing cycle is frozen.
  - stall=0 in DONE unless a new start arrives, so EX/MEM captures result that cycle.
- start while RUN: ignored. The pipeline is stalled, so upstream holds start; it is accepted in DONE.
- flush=1:
  - Forces IDLE next cycle and suppresses done. result keeps its old value.
  - flush has priority over start and over the RUN->DONE transition.
- rst has priority over flush.
- Divide by zero: no special path. The algorithm naturally yields quotient=all-ones and remainder=op_a. div_zero=1 with done; the latency is unchanged.
- MULLO/MULHI: low/high WIDTH bits of the 2*WIDTH unsigned product. No overflow flag.
- All arithmetic is unsigned, WIDTH+1-bit subtract for the compare.
- Operand changes on op_a/op_b after the start cycle have no effect.

Decomposition:
- Shared package (cpu_pkg): op encodings MD_MULLO/MD_MULHI/MD_DIVQ/MD_DIVR, state encodings, WIDTH default.
- One natural sub-module, md_datapath: product/remainder shift registers and adder/subtractor, stepped by an enable.
- The FSM, counter and stall logic stay in the top module.

Test Plan:
- MULLO 0x1234*0x0010, start 1 cycle -> stall high 17 cycles; done at cycle 17; result=0x2340; div_zero=0.
- MULHI 0xFFFF*0xFFFF -> result=0xFFFE. Repeat with MULLO -> 0x0001.
- DIVQ 100/7 -> result=0x000E. DIVR same operands -> 0x0002. Verify 17-cycle latency each.
- DIVQ 0x1234/0 -> result=0xFFFF, div_zero=1. DIVR 0x1234/0 -> 0x1234, div_zero=1.
- Start MULLO, flush at cycle 5 -> IDLE next cycle, stall=0, no done pulse, result unchanged. Back-to-back start in DONE cycle -> second op completes 17 cycles later.
- rst asserted mid-RUN (cycle 8) with flush=1 -> all outputs 0 next cycle, state IDLE. New start then completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: mul/div opcodes, FSM states, default width.
package cpu_pkg;

    localparam int unsigned MD_WIDTH = 16;

    // Mul/div operation select carried from ID/EX (all unsigned)
    typedef enum logic [1:0] {
        MD_MULLO = 2'b00,
        MD_MULHI = 2'b01,
        MD_DIVQ  = 2'b10,
        MD_DIVR  = 2'b11
    } md_op_e;

    // Iterative mul/div sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Shared shift register and adder/subtractor for radix-2 shift-add multiply and restoring divide.
// acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
module md_datapath
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_step
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;

    // One iteration of the selected algorithm, computed from the current register contents
    always_comb begin
        // Carry out of the upper-half add is kept and shifted into the product MSB
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        if (is_div) begin
            if (div_diff[WIDTH+1]) begin
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Load operands on accept, otherwise advance one iteration when enabled
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, a};
            opnd_d = b;
        end else if (step) begin
            acc_d = acc_step;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit: sequencer, iteration counter, stall and result capture.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q;
    logic               div_zero_r_q;
    logic [WIDTH-1:0]   result_q;
    logic               div_zero_q;
    logic               accept;
    logic               finish;
    logic               last_iter;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   result_sel;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept    = start & ~flush & ((state_q == StIdle) | (state_q == StDone));
    assign finish    = (state_q == StRun) & last_iter & ~flush;

    // Next state and counter; flush overrides everything except reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // Pipeline handshake; stall is combinational so the issuing cycle itself is frozen
    always_comb begin
        stall    = (start & ((state_q == StIdle) | (state_q == StDone))) | (state_q == StRun);
        done     = (state_q == StDone);
        result   = result_q;
        div_zero = div_zero_q;
    end

    // Pick the product half or quotient/remainder out of the final iteration's value
    always_comb begin
        result_sel = '0;
        unique case (op_q)
            MD_MULLO, MD_DIVQ: result_sel = acc_step[WIDTH-1:0];
            MD_MULHI, MD_DIVR: result_sel = acc_step[2*WIDTH-1:WIDTH];
            default:           result_sel = '0;
        endcase
    end

    // Sequencer state, latched op info and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= MD_MULLO;
            div_zero_r_q <= 1'b0;
            result_q     <= '0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q         <= md_op_e'(op);
                div_zero_r_q <= op[1] & (op_b == '0);
                div_zero_q   <= 1'b0;
            end
            if (finish) begin
                result_q   <= result_sel;
                div_zero_q <= div_zero_r_q;
            end
        end
    end

    md_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (state_q == StRun),
        .is_div  (op_q[1]),
        .a       (op_a),
        .b       (op_b),
        .acc_step(acc_step)
    );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [15:0] result;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(
        .WIDTH(16),
        .CNT_W(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result),
        .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a start for one cycle, then scramble operands to prove they were latched
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input string tag);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        #1;
        check({tag, " issue stall"}, {31'd0, stall}, 32'd1);
        next_cycle();
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
    endtask

    // From cycle 1 after issue: expect 16 stalled cycles, then done in cycle 17
    task automatic expect_done(input logic [15:0] exp_res, input logic exp_dz,
                               input bit chk_stall, input string tag);
        bit ok = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (!(stall === 1'b1 && done === 1'b0)) ok = 1'b0;
            next_cycle();
        end
        check({tag, " run stall"}, {31'd0, ok}, 32'd1);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
        if (chk_stall) check({tag, " done stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        bit quiet;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {16'd0, result}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);

        issue(2'b00, 16'h1234, 16'h0010, "mullo_a");
        expect_done(16'h2340, 1'b0, 1'b1, "mullo_a");
        next_cycle();
        check("post done pulse", {31'd0, done}, 32'd0);
        check("post done hold", {16'd0, result}, 32'h2340);

        issue(2'b01, 16'hFFFF, 16'hFFFF, "mulhi_ff");
        expect_done(16'hFFFE, 1'b0, 1'b1, "mulhi_ff");
        next_cycle();
        issue(2'b00, 16'hFFFF, 16'hFFFF, "mullo_ff");
        expect_done(16'h0001, 1'b0, 1'b1, "mullo_ff");
        next_cycle();

        issue(2'b10, 16'd100, 16'd7, "divq_100_7");
        expect_done(16'h000E, 1'b0, 1'b1, "divq_100_7");
        next_cycle();
        issue(2'b11, 16'd100, 16'd7, "divr_100_7");
        expect_done(16'h0002, 1'b0, 1'b1, "divr_100_7");
        next_cycle();

        issue(2'b10, 16'h1234, 16'h0000, "divq_zero");
        expect_done(16'hFFFF, 1'b1, 1'b1, "divq_zero");
        next_cycle();
        issue(2'b11, 16'h1234, 16'h0000, "divr_zero");
        expect_done(16'h1234, 1'b1, 1'b1, "divr_zero");
        next_cycle();
        check("div_zero held", {31'd0, div_zero}, 32'd1);

        // Flush mid-run: back to idle, no done, result untouched
        issue(2'b00, 16'h0003, 16'h0005, "flush");
        check("new op clears div_zero", {31'd0, div_zero}, 32'd0);
        for (int i = 1; i < 5; i++) next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check("flush stall", {31'd0, stall}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result", {16'd0, result}, 32'h1234);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done !== 1'b0) quiet = 1'b0;
            next_cycle();
        end
        check("flush no done", {31'd0, quiet}, 32'd1);

        // Back-to-back: second start arrives in the first op's done cycle
        issue(2'b00, 16'h0003, 16'h0005, "b2b_first");
        expect_done(16'h000F, 1'b0, 1'b1, "b2b_first");
        issue(2'b01, 16'h8000, 16'h0004, "b2b_second");
        expect_done(16'h0002, 1'b0, 1'b1, "b2b_second");
        next_cycle();

        // Reset with flush mid-run
        issue(2'b00, 16'h1111, 16'h0002, "rst_mid");
        for (int i = 1; i < 8; i++) next_cycle();
        rst   = 1'b1;
        flush = 1'b1;
        next_cycle();
        rst   = 1'b0;
        flush = 1'b0;
        check("rst_mid stall", {31'd0, stall}, 32'd0);
        check("rst_mid done", {31'd0, done}, 32'd0);
        check("rst_mid result", {16'd0, result}, 32'd0);
        check("rst_mid div_zero", {31'd0, div_zero}, 32'd0);
        next_cycle();
        issue(2'b10, 16'd100, 16'd7, "after_rst");
        expect_done(16'h000E, 1'b0, 1'b1, "after_rst");
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
